// File: rtl/riscy_pkg.sv
// Shared types and word geometry for the program loader.
package riscy_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        FLUSH,
        DONE,
        ERR
    } loader_state_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte valid/ready stream feeding the program loader.
interface program_loader_if;

    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;

    modport master (output s_data, output s_valid, input  s_ready);
    modport slave  (input  s_data, input  s_valid, output s_ready);

endinterface

// File: rtl/program_loader_byte_packer.sv
// Little-endian byte-to-word assembler shared by the header and data phases.
module byte_packer
    import riscy_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              en,
    input  logic [7:0]        data,
    output logic              word_done,
    output logic [WORD_W-1:0] word
);

    logic [1:0]        r_cnt;
    logic [WORD_W-9:0] r_shift;

    // The completed word is visible combinationally in the cycle its last byte arrives.
    assign word      = {data, r_shift};
    assign word_done = en && (r_cnt == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (clear) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (en) begin
            r_cnt   <= r_cnt + 2'd1;
            r_shift <= word[WORD_W-1:8];
        end
    end

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed byte stream into instruction memory, then releases the core.
//   state | meaning
//   IDLE  | after reset, waiting for start
//   HDR   | collecting 4-byte word count
//   DATA  | assembling and writing program words
//   FLUSH | final write pulse, stream closed
//   DONE  | program loaded, core running
//   ERR   | header rejected
module program_loader
    import riscy_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    program_loader_if.slave   s,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic [ADDR_W:0]   len,
    output logic              cpu_run,
    output logic              busy,
    output logic              error
);

    loader_state_t     r_state;
    logic [ADDR_W-1:0] r_k;
    logic [ADDR_W:0]   r_len;
    logic              r_s_ready;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata;
    logic              r_cpu_run;
    logic              r_busy;
    logic              r_error;

    logic              w_accept;
    logic              w_clear;
    logic              w_word_done;
    logic [WORD_W-1:0] w_word;
    logic              w_hdr_bad;
    logic              w_last;

    assign w_accept  = s.s_valid && r_s_ready;
    assign w_clear   = start && (r_state == IDLE || r_state == DONE || r_state == ERR);
    // Full 32-bit compare so header bits above ADDR_W cannot alias into range.
    assign w_hdr_bad = (w_word == '0) || (w_word > 32'(DEPTH));
    assign w_last    = ({1'b0, r_k} == (r_len - (ADDR_W+1)'(1)));

    byte_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (w_clear),
        .en        (w_accept),
        .data      (s.s_data),
        .word_done (w_word_done),
        .word      (w_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_k       <= '0;
            r_len     <= '0;
            r_s_ready <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_cpu_run <= 1'b0;
            r_busy    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        r_state   <= HDR;
                        r_len     <= '0;
                        r_s_ready <= 1'b1;
                        r_busy    <= 1'b1;
                        r_cpu_run <= 1'b0;
                        r_error   <= 1'b0;
                    end
                end
                HDR: begin
                    if (w_word_done) begin
                        if (w_hdr_bad) begin
                            r_state   <= ERR;
                            r_error   <= 1'b1;
                            r_s_ready <= 1'b0;
                            r_busy    <= 1'b0;
                            r_len     <= '0;
                        end else begin
                            r_state <= DATA;
                            r_len   <= w_word[ADDR_W:0];
                            r_k     <= '0;
                        end
                    end
                end
                DATA: begin
                    if (w_word_done) begin
                        r_we    <= 1'b1;
                        r_addr  <= r_k;
                        r_wdata <= w_word;
                        r_k     <= r_k + ADDR_W'(1);
                        if (w_last) begin
                            r_state   <= FLUSH;
                            r_s_ready <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    r_state   <= DONE;
                    r_cpu_run <= 1'b1;
                    r_busy    <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s.s_ready  = r_s_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign len        = r_len;
    assign cpu_run    = r_cpu_run;
    assign busy       = r_busy;
    assign error      = r_error;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: vector table of loads plus reset and restart sequences.
module tb_program_loader;
    import riscy_pkg::*;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   len;
    logic              cpu_run;
    logic              busy;
    logic              error;

    program_loader_if sif();

    program_loader #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .s          (sif),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .len        (len),
        .cpu_run    (cpu_run),
        .busy       (busy),
        .error      (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hdr;
        bit          exp_err;
        bit          bubbles;
        bit          fixed;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t         sb[$];
    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    int          exp_pulses = 0;
    logic [31:0] fixed_w [2];
    vec_t        vecs [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write monitor: every imem_we pulse must match the next expected write.
    always @(negedge clk) begin
        if (rst_n && imem_we === 1'b1) begin
            wr_t e;
            pulses++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0h data %0h, none expected", imem_addr, imem_wdata);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", 64'(imem_addr), 64'(e.addr));
                chk("wr_data", 64'(imem_wdata), 64'(e.data));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit bub);
        int n;
        @(negedge clk);
        if (bub) begin
            repeat ($urandom_range(0, 2)) begin
                sif.s_valid = 1'b0;
                @(negedge clk);
            end
        end
        sif.s_valid = 1'b1;
        sif.s_data  = b;
        n = 0;
        while (sif.s_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 64'(sif.s_ready), 64'd1);
        @(posedge clk);
    endtask

    task automatic idle_stream();
        @(negedge clk);
        sif.s_valid = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_ready", 64'(sif.s_ready), 64'd1);
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_len", 64'(len), 64'd0);
        chk("start_run", 64'(cpu_run), 64'd0);
        chk("start_err", 64'(error), 64'd0);
    endtask

    task automatic load(input logic [31:0] hdr, input bit exp_err, input bit bub, input bit fixed);
        logic [31:0] w;
        int          n;
        do_start();
        for (int i = 0; i < 4; i++) send_byte(hdr[8*i +: 8], bub);
        if (exp_err) begin
            idle_stream();
            chk("err_flag", 64'(error), 64'd1);
            chk("err_ready", 64'(sif.s_ready), 64'd0);
            chk("err_busy", 64'(busy), 64'd0);
            chk("err_len", 64'(len), 64'd0);
            chk("err_run", 64'(cpu_run), 64'd0);
            repeat (2) @(negedge clk);
            chk("err_hold", 64'(error), 64'd1);
        end else begin
            n = int'(hdr);
            for (int k = 0; k < n; k++) begin
                w = fixed ? fixed_w[k] : $urandom;
                for (int b = 0; b < 4; b++) begin
                    if (b == 3) begin
                        sb.push_back('{addr: ADDR_W'(k), data: w});
                        exp_pulses++;
                    end
                    send_byte(w[8*b +: 8], bub);
                end
            end
            idle_stream();
            chk("flush_we", 64'(imem_we), 64'd1);
            chk("flush_addr", 64'(imem_addr), 64'(n - 1));
            chk("flush_ready", 64'(sif.s_ready), 64'd0);
            chk("flush_busy", 64'(busy), 64'd1);
            chk("flush_run", 64'(cpu_run), 64'd0);
            @(negedge clk);
            #1;
            chk("done_run", 64'(cpu_run), 64'd1);
            chk("done_busy", 64'(busy), 64'd0);
            chk("done_len", 64'(len), 64'(n));
            chk("done_we", 64'(imem_we), 64'd0);
            chk("done_sb_empty", 64'(sb.size()), 64'd0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"}, 64'(imem_we), 64'd0);
        chk({tag, "_addr"}, 64'(imem_addr), 64'd0);
        chk({tag, "_wdata"}, 64'(imem_wdata), 64'd0);
        chk({tag, "_len"}, 64'(len), 64'd0);
        chk({tag, "_run"}, 64'(cpu_run), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_err"}, 64'(error), 64'd0);
        chk({tag, "_ready"}, 64'(sif.s_ready), 64'd0);
    endtask

    initial begin
        logic [31:0] w;
        fixed_w[0] = 32'h0050_0013;
        fixed_w[1] = 32'h00A0_0093;
        vecs[0] = '{hdr: 32'd2,          exp_err: 1'b0, bubbles: 1'b0, fixed: 1'b1};
        vecs[1] = '{hdr: 32'd0,          exp_err: 1'b1, bubbles: 1'b0, fixed: 1'b0};
        vecs[2] = '{hdr: 32'h0000_0101,  exp_err: 1'b1, bubbles: 1'b0, fixed: 1'b0};
        vecs[3] = '{hdr: 32'd256,        exp_err: 1'b0, bubbles: 1'b0, fixed: 1'b0};
        vecs[4] = '{hdr: 32'd3,          exp_err: 1'b0, bubbles: 1'b1, fixed: 1'b0};
        vecs[5] = '{hdr: 32'h0100_0100,  exp_err: 1'b1, bubbles: 1'b0, fixed: 1'b0};
        vecs[6] = '{hdr: 32'd1,          exp_err: 1'b0, bubbles: 1'b1, fixed: 1'b0};
        vecs[7] = '{hdr: 32'h8000_0001,  exp_err: 1'b1, bubbles: 1'b1, fixed: 1'b0};
        vecs[8] = '{hdr: 32'd5,          exp_err: 1'b0, bubbles: 1'b0, fixed: 1'b0};

        sif.s_valid = 1'b0;
        sif.s_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        foreach (vecs[i]) load(vecs[i].hdr, vecs[i].exp_err, vecs[i].bubbles, vecs[i].fixed);

        // Reset midway through word 1 of an N=4 load.
        do_start();
        for (int i = 0; i < 4; i++) send_byte(8'(32'd4 >> (8*i)), 1'b0);
        w = 32'hDEAD_BEEF;
        for (int b = 0; b < 4; b++) begin
            if (b == 3) begin
                sb.push_back('{addr: '0, data: w});
                exp_pulses++;
            end
            send_byte(w[8*b +: 8], 1'b0);
        end
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        sif.s_valid = 1'b0;
        rst_n = 1'b1;
        load(32'd2, 1'b0, 1'b0, 1'b1);

        // Restart from DONE with a one-word program.
        load(32'd1, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("pulse_count", 64'(pulses), 64'(exp_pulses));
        chk("sb_final_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
